axi_mem_slave: RTL and testbench

AXI4 responder endpoint that terminates one master port of the AXI crossbar in an on-chip 512-bit-wide RAM. It accepts AW/W bursts and returns B, and accepts AR bursts and returns R beats, echoing the request ID. It is used as a simulation and bring-up target in place of DDR/PCIe.

---
 rtl/axi_mem_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 responder terminating one crossbar port in a 512-bit on-chip RAM (INCR bursts, ID echo).
// Latency: wready 1 cycle after AW, first rvalid 2 cycles after AR; backpressure via a 2-entry R skid buffer and a held B.
module axi_mem_slave #(
  parameter int MEM_LD = 10,
  parameter bit EN_WR  = 1'b1,
  parameter bit EN_RD  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         awvalid,
  output logic         awready,
  input  logic [15:0]  awid,
  input  logic [63:0]  awaddr,
  input  logic [7:0]   awlen,
  input  logic [2:0]   awsize,
  input  logic         wvalid,
  output logic         wready,
  input  logic [511:0] wdata,
  input  logic [63:0]  wstrb,
  input  logic         wlast,
  output logic         bvalid,
  input  logic         bready,
  output logic [15:0]  bid,
  output logic [1:0]   bresp,
  input  logic         arvalid,
  output logic         arready,
  input  logic [15:0]  arid,
  input  logic [63:0]  araddr,
  input  logic [7:0]   arlen,
  input  logic [2:0]   arsize,
  output logic         rvalid,
  input  logic         rready,
  output logic [15:0]  rid,
  output logic [511:0] rdata,
  output logic [1:0]   rresp,
  output logic         rlast
);
  localparam int DEPTH = 1 << MEM_LD;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [1:0] req_code(input logic [48:0] addr, input logic [2:0] size);
    if ((addr >> (6 + MEM_LD)) != '0) return DECERR;
    if (size != 3'd6)                 return SLVERR;
    return OKAY;
  endfunction

  logic [511:0] mem [0:DEPTH-1];
  logic [511:0] ram_rd_q;

  w_state_e            w_state_q, w_state_d;
  logic [15:0]         bid_q, bid_d;
  logic [MEM_LD-1:0]   wline_q, wline_d;
  logic [7:0]          wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [1:0]          wcode_q, wcode_d;
  logic                live_q;
  logic                mem_we, aw_hs, w_hs;

  r_state_e            r_state_q, r_state_d;
  logic [15:0]         rid_q, rid_d;
  logic [MEM_LD-1:0]   rline_q, rline_d;
  logic [7:0]          rlen_q, rlen_d;
  logic [1:0]          rcode_q, rcode_d;
  logic [8:0]          iss_cnt_q, iss_cnt_d;
  logic                pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [511:0]        buf_dat_q [0:1];
  logic [511:0]        buf_dat_d [0:1];
  logic [1:0]          buf_last_q, buf_last_d;
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2:0]          occ;
  logic                ar_hs, pop, issue;
  logic                unused_ok;

  assign unused_ok = ^{awaddr[63:49], awaddr[5:0], araddr[63:49], araddr[5:0]};

  // Read-first RAM: the read port always samples the current issue line.
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 64; b++)
        if (wstrb[b]) mem[wline_q][b*8 +: 8] <= wdata[b*8 +: 8];
    ram_rd_q <= mem[rline_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      w_state_q   <= W_IDLE;
      bid_q       <= '0;
      wline_q     <= '0;
      wlen_q      <= '0;
      wbeat_q     <= '0;
      wcode_q     <= OKAY;
      r_state_q   <= R_IDLE;
      rid_q       <= '0;
      rline_q     <= '0;
      rlen_q      <= '0;
      rcode_q     <= OKAY;
      iss_cnt_q   <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_last_q <= 1'b0;
      buf_dat_q   <= '{default: '0};
      buf_last_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      live_q      <= 1'b1;
      w_state_q   <= w_state_d;
      bid_q       <= bid_d;
      wline_q     <= wline_d;
      wlen_q      <= wlen_d;
      wbeat_q     <= wbeat_d;
      wcode_q     <= wcode_d;
      r_state_q   <= r_state_d;
      rid_q       <= rid_d;
      rline_q     <= rline_d;
      rlen_q      <= rlen_d;
      rcode_q     <= rcode_d;
      iss_cnt_q   <= iss_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      buf_dat_q   <= buf_dat_d;
      buf_last_q  <= buf_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    mem_we    = 1'b0;
    w_state_d = w_state_q;
    bid_d     = bid_q;
    wline_d   = wline_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wcode_d   = wcode_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        bid_d     = awid;
        wline_d   = awaddr[6 +: MEM_LD];
        wlen_d    = awlen;
        wbeat_d   = '0;
        wcode_d   = req_code(awaddr[48:0], awsize);
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        mem_we  = (wcode_q == OKAY);
        wline_d = wline_q + MEM_LD'(1);
        wbeat_d = wbeat_q + 8'd1;
        if (wlast) begin
          w_state_d = W_RESP;
          if (wbeat_q != wlen_q && wcode_q == OKAY) wcode_d = SLVERR;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Issue a RAM read only when the skid buffer can absorb it, counting the in-flight beat and this cycle's pop.
  always_comb begin
    ar_hs       = arvalid && arready;
    pop         = rvalid && rready;
    occ         = {1'b0, cnt_q} + {2'b0, pipe_vld_q} - {2'b0, pop};
    issue       = (r_state_q == R_DATA) && (iss_cnt_q <= {1'b0, rlen_q}) && (occ < 3'd2);
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    rline_d     = rline_q;
    rlen_d      = rlen_q;
    rcode_d     = rcode_q;
    iss_cnt_d   = iss_cnt_q;
    pipe_vld_d  = issue;
    pipe_last_d = issue && (iss_cnt_q[7:0] == rlen_q);
    buf_dat_d   = buf_dat_q;
    buf_last_d  = buf_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + {1'b0, pipe_vld_q} - {1'b0, pop};
    if (r_state_q == R_IDLE && ar_hs) begin
      rid_d     = arid;
      rline_d   = araddr[6 +: MEM_LD];
      rlen_d    = arlen;
      rcode_d   = req_code(araddr[48:0], arsize);
      iss_cnt_d = '0;
      r_state_d = R_DATA;
    end
    if (issue) begin
      rline_d   = rline_q + MEM_LD'(1);
      iss_cnt_d = iss_cnt_q + 9'd1;
    end
    if (pipe_vld_q) begin
      buf_dat_d[wr_ptr_q]  = (rcode_q == OKAY) ? ram_rd_q : '0;
      buf_last_d[wr_ptr_q] = pipe_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (buf_last_q[rd_ptr_q]) r_state_d = R_IDLE;
    end
  end

  always_comb begin
    awready = EN_WR && live_q && (w_state_q == W_IDLE);
    wready  = EN_WR && live_q && (w_state_q == W_DATA);
    bvalid  = EN_WR && (w_state_q == W_RESP);
    bid     = bid_q;
    bresp   = bvalid ? wcode_q : OKAY;
    arready = EN_RD && live_q && (r_state_q == R_IDLE);
    rvalid  = EN_RD && (cnt_q != 2'd0);
    rid     = rid_q;
    rdata   = rvalid ? buf_dat_q[rd_ptr_q] : '0;
    rlast   = rvalid && buf_last_q[rd_ptr_q];
    rresp   = rvalid ? rcode_q : OKAY;
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: directed scenarios then randomized bursts against a line-array memory model.
module tb_axi_mem_slave;
  localparam int MEM_LD = 4;
  localparam int NL     = 1 << MEM_LD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [15:0]  awid, bid, arid, rid;
  logic [63:0]  awaddr, araddr, wstrb;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [511:0] wdata, rdata;
  logic [1:0]   bresp, rresp;

  axi_mem_slave #(.MEM_LD(MEM_LD), .EN_WR(1'b1), .EN_RD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  logic [511:0] model [0:NL-1];
  logic [511:0] wd [0:15];
  logic [63:0]  ws [0:15];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] exp_code(input logic [63:0] addr, input logic [2:0] size);
    if (addr[48:10] != '0) return 2'b11;
    if (size != 3'd6)      return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"},  wready, 0);
    chk({tag, "_bvalid"},  bvalid, 0);
    chk({tag, "_bresp"},   bresp, 0);
    chk({tag, "_bid"},     bid, 0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_rvalid"},  rvalid, 0);
    chk({tag, "_rlast"},   rlast, 0);
    chk({tag, "_rresp"},   rresp, 0);
    chk({tag, "_rid"},     rid, 0);
    chk({tag, "_rdata"},   rdata, 0);
  endtask

  task automatic axi_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                           input logic [15:0] id, input int last_at, input int bdelay, input int abort_after);
    logic [1:0] code;
    int line, n;
    code = exp_code(addr, size);
    line = int'(addr[9:6]);
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len[7:0]; awsize = size;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    chk("aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("w_ready_lat1", wready, 1);
    for (int b = 0; b <= last_at; b++) begin
      if (b == abort_after) begin
        rst_n = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at);
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      chk("w_ready", wready, 1);
      if (code == 2'b00)
        for (int by = 0; by < 64; by++)
          if (ws[b][by]) model[(line + b) % NL][by*8 +: 8] = wd[b][by*8 +: 8];
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (last_at != len && code == 2'b00) code = 2'b10;
    for (int k = 0; k < bdelay; k++) begin
      chk("b_hold_bvalid", bvalid, 1);
      chk("b_hold_awready", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    chk("b_valid", bvalid, 1);
    chk("b_resp", bresp, code);
    chk("b_id", bid, id);
    @(negedge clk);
    bready = 1'b0;
    chk("b_drop", bvalid, 0);
  endtask

  task automatic axi_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                          input logic [15:0] id, input int rmode);
    logic [1:0]   code;
    logic [511:0] pd, ed;
    logic         pl, stalled, rr;
    logic [1:0]   pr;
    logic [15:0]  pi;
    int line, n, beat, k;
    code = exp_code(addr, size);
    line = int'(addr[9:6]);
    stalled = 1'b0; beat = 0; k = 0;
    pd = '0; pl = 1'b0; pr = '0; pi = '0;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len[7:0]; arsize = size;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    chk("r_first_lat", n - 1, 2);
    while (beat <= len && k < 400) begin
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      rready = rr;
      if (stalled) begin
        chk("r_stall_vld", rvalid, 1);
        chk("r_stall_dat", rdata, pd);
        chk("r_stall_last", rlast, pl);
        chk("r_stall_resp", rresp, pr);
        chk("r_stall_id", rid, pi);
      end
      if (rvalid) begin
        if (rr) begin
          ed = (code != 2'b00) ? '0 : model[(line + beat) % NL];
          chk("r_data", rdata, ed);
          chk("r_resp", rresp, code);
          chk("r_id", rid, id);
          chk("r_last", rlast, beat == len);
          beat++;
        end
        stalled = !rr;
        pd = rdata; pl = rlast; pr = rresp; pi = rid;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    rready = 1'b0;
    chk("r_beats", beat, len + 1);
    chk("r_idle_rvalid", rvalid, 0);
    chk("r_idle_arready", arready, 1);
  endtask

  initial begin
    logic [63:0] a;
    int len, last_at;
    logic [2:0] sz;
    rst_n = 1'b0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; rready = 0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);

    for (int i = 0; i < 16; i++) begin wd[i] = rnd512(); ws[i] = '1; end
    axi_write(64'h0, 15, 3'd6, 16'h0001, 15, 0, -1);

    wd[0] = rnd512(); ws[0] = '1;
    axi_write(64'h40, 0, 3'd6, 16'h0012, 0, 0, -1);
    axi_read(64'h40, 0, 3'd6, 16'h0034, 0);

    wd[0] = '1; ws[0] = '1;
    axi_write(64'd5 << 6, 0, 3'd6, 16'h0005, 0, 0, -1);
    wd[0] = rnd512(); wd[0][7:0] = 8'hAA; ws[0] = 64'h1;
    axi_write(64'd5 << 6, 0, 3'd6, 16'h0006, 0, 0, -1);
    axi_read(64'd5 << 6, 0, 3'd6, 16'h0007, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = rnd512(); ws[i] = '1; end
    axi_write(64'h3C0, 3, 3'd6, 16'h00A0, 3, 0, -1);
    axi_read(64'h3C0, 3, 3'd6, 16'h00A1, 0);

    wd[0] = rnd512(); ws[0] = '1;
    axi_write(64'd1 << 40, 0, 3'd6, 16'h00B0, 0, 0, -1);
    axi_read(64'h0, 0, 3'd6, 16'h00B1, 0);
    axi_read(64'd1 << 40, 1, 3'd6, 16'h00B2, 0);

    axi_read(64'h80, 1, 3'd5, 16'h00C0, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = rnd512(); ws[i] = '1; end
    axi_write(64'h100, 3, 3'd6, 16'h00D0, 1, 0, -1);

    axi_read(64'h0, 7, 3'd6, 16'h00E0, 1);
    wd[0] = rnd512(); ws[0] = '1;
    axi_write(64'h200, 0, 3'd6, 16'h00E1, 0, 10, -1);

    for (int i = 0; i < 4; i++) begin wd[i] = rnd512(); ws[i] = '1; end
    axi_write(64'h280, 3, 3'd6, 16'h00F0, 3, 0, 2);
    wd[0] = rnd512(); ws[0] = '1;
    axi_write(64'h40, 0, 3'd6, 16'h00F1, 0, 0, -1);
    axi_read(64'h280, 3, 3'd6, 16'h00F2, 0);

    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(0, 7);
      a = 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(10, 48));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd6;
      last_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
      for (int i = 0; i < 16; i++) begin wd[i] = rnd512(); ws[i] = {$urandom, $urandom}; end
      axi_write(a, len, sz, 16'($urandom), last_at, $urandom_range(0, 3), -1);
      len = $urandom_range(0, 7);
      a = 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(10, 48));
      sz = ($urandom_range(0, 7) == 0) ? 3'd5 : 3'd6;
      axi_read(a, len, sz, 16'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
